// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Fixed-latency memory model that responds to a simple processor bus.
//   Requests get a tag in the cycle they are accepted and complete exactly
//   LATENCY cycles later, in acceptance order. The storage is a word array
//   that reset does not clear.
//
// Parameters
//   DEPTH_WORDS      number of 32-bit words of backing storage
//   LATENCY          cycles from acceptance to completion (1..15)
//   MAX_OUTSTANDING  accepted but not yet completed requests allowed (1..15)
//
// Ports
//   clk                in   1   clock, rising edge
//   rst                in   1   synchronous reset, active low
//   proc2mem_command   in   2   0 none, 1 load, 2 store, 3 treated as none
//   proc2mem_addr      in  32   byte address, word index = addr[31:2]
//   proc2mem_data      in  32   store data
//   mem2proc_response  out  4   combinational tag granted this cycle, 0 = none
//   mem2proc_data      out 32   registered load data of completing request
//   mem2proc_tag       out  4   registered tag of completing request, 0 = none
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int DEPTH_WORDS     = 1024,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  proc2mem_command,
    input  logic [31:0] proc2mem_addr,
    input  logic [31:0] proc2mem_data,
    output logic [3:0]  mem2proc_response,
    output logic [31:0] mem2proc_data,
    output logic [3:0]  mem2proc_tag
);

    localparam int         AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int         QW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [3:0] CD_INIT = 4'(LATENCY - 1);
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);
    // With a single-cycle latency the request completes on the very next
    // cycle, so it skips the queue and goes straight to the output registers.
    localparam bit         BYPASS  = (LATENCY == 1);

    // Backing storage (never reset)
    logic [31:0] r_mem [DEPTH_WORDS];

    // In-order request queue, circular buffer
    logic [3:0]  r_q_tag  [MAX_OUTSTANDING];
    logic [31:0] r_q_data [MAX_OUTSTANDING];
    logic        r_q_load [MAX_OUTSTANDING];
    logic [3:0]  r_q_cd   [MAX_OUTSTANDING];
    logic [QW-1:0] r_wr_ptr;
    logic [QW-1:0] r_rd_ptr;
    logic [3:0]    r_q_cnt;

    // Requests accepted and not yet past their completion cycle. A request
    // still counts during the cycle in which its tag is on mem2proc_tag.
    logic [3:0]  r_out_cnt;
    logic [3:0]  r_next_tag;
    logic [3:0]  r_tag;
    logic [31:0] r_data;

    logic          w_is_load;
    logic          w_is_store;
    logic          w_completing;
    logic          w_accept;
    logic          w_push;
    logic          w_head_due;
    logic [31:0]   w_word_idx;
    logic          w_in_range;
    logic [AW-1:0] w_mem_idx;
    logic [31:0]   w_rd_word;
    logic [3:0]    w_tag_inc;
    logic          w_unused;

    function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
        return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_is_load    = (proc2mem_command == 2'd1);
    assign w_is_store   = (proc2mem_command == 2'd2);
    assign w_completing = (r_tag != 4'd0);

    // A completion in this cycle frees a slot at the same edge, so a full
    // queue can still accept while its head is retiring.
    assign w_accept = rst && (w_is_load || w_is_store) &&
                      ((r_out_cnt < MAX_OUT) || w_completing);
    assign w_push   = w_accept && !BYPASS;

    assign mem2proc_response = w_accept ? r_next_tag : 4'd0;
    assign mem2proc_tag      = r_tag;
    assign mem2proc_data     = r_data;

    assign w_word_idx = {2'b00, proc2mem_addr[31:2]};
    assign w_in_range = (w_word_idx < 32'(DEPTH_WORDS));
    assign w_mem_idx  = w_word_idx[AW-1:0];
    assign w_rd_word  = w_in_range ? r_mem[w_mem_idx] : 32'd0;
    assign w_unused   = ^{proc2mem_addr[1:0]};

    // Head retires into the output registers when its countdown shows one
    // cycle left; the registers then present it during its completion cycle.
    assign w_head_due = (r_q_cnt != 4'd0) && (r_q_cd[r_rd_ptr] == 4'd1);

    // Tags run 1..15 and never 0, which is reserved for "nothing".
    assign w_tag_inc = (r_next_tag == 4'd15) ? 4'd1 : r_next_tag + 4'd1;

    always_ff @(posedge clk) begin
        if (w_accept && w_is_store && w_in_range) begin
            r_mem[w_mem_idx] <= proc2mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_q_tag[i]  <= 4'd0;
                r_q_data[i] <= 32'd0;
                r_q_load[i] <= 1'b0;
                r_q_cd[i]   <= 4'd0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_q_cnt    <= 4'd0;
            r_out_cnt  <= 4'd0;
            r_next_tag <= 4'd1;
            r_tag      <= 4'd0;
            r_data     <= 32'd0;
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (r_q_cd[i] != 4'd0) begin
                    r_q_cd[i] <= r_q_cd[i] - 4'd1;
                end
            end

            // Output registers: one completion at most, held for one cycle.
            if (BYPASS && w_accept) begin
                r_tag  <= r_next_tag;
                r_data <= w_is_load ? w_rd_word : 32'd0;
            end else if (w_head_due) begin
                r_tag    <= r_q_tag[r_rd_ptr];
                r_data   <= r_q_load[r_rd_ptr] ? r_q_data[r_rd_ptr] : 32'd0;
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end else begin
                r_tag  <= 4'd0;
                r_data <= 32'd0;
            end

            // The slot being written is empty, so its countdown is already 0
            // and this write cannot collide with a live decrement.
            if (w_push) begin
                r_q_tag[r_wr_ptr]  <= r_next_tag;
                r_q_data[r_wr_ptr] <= w_is_load ? w_rd_word : 32'd0;
                r_q_load[r_wr_ptr] <= w_is_load;
                r_q_cd[r_wr_ptr]   <= CD_INIT;
                r_wr_ptr           <= ptr_inc(r_wr_ptr);
            end

            case ({w_push, w_head_due})
                2'b10:   r_q_cnt <= r_q_cnt + 4'd1;
                2'b01:   r_q_cnt <= r_q_cnt - 4'd1;
                default: r_q_cnt <= r_q_cnt;
            endcase

            case ({w_accept, w_completing})
                2'b10:   r_out_cnt <= r_out_cnt + 4'd1;
                2'b01:   r_out_cnt <= r_out_cnt - 4'd1;
                default: r_out_cnt <= r_out_cnt;
            endcase

            if (w_accept) begin
                r_next_tag <= w_tag_inc;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Two responders: U0 with the default LATENCY=4 / MAX_OUTSTANDING=4 and U1
//   with LATENCY=6 / MAX_OUTSTANDING=2 so that back-pressure shows up.
//   A transaction-level model (list of pending completions with their due
//   cycle, a word array, a tag counter) predicts every output every cycle;
//   directed sequences add constant expectations on top.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int DEPTH = 1024;
    localparam int L0 = 4, M0 = 4;
    localparam int L1 = 6, M1 = 2;

    logic        clk;
    logic        rst;
    logic [1:0]  cmd   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  resp  [2];
    logic [31:0] odata [2];
    logic [3:0]  otag  [2];

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L0), .MAX_OUTSTANDING(M0)) u0 (
        .clk(clk), .rst(rst),
        .proc2mem_command(cmd[0]), .proc2mem_addr(addr[0]), .proc2mem_data(wdata[0]),
        .mem2proc_response(resp[0]), .mem2proc_data(odata[0]), .mem2proc_tag(otag[0]));

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L1), .MAX_OUTSTANDING(M1)) u1 (
        .clk(clk), .rst(rst),
        .proc2mem_command(cmd[1]), .proc2mem_addr(addr[1]), .proc2mem_data(wdata[1]),
        .mem2proc_response(resp[1]), .mem2proc_data(odata[1]), .mem2proc_tag(otag[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
        int          done;
    } pend_t;

    pend_t       pq [2][$];
    logic [31:0] mm [2][16];
    int          outst [2];
    logic [3:0]  ntag [2];
    int          cyc;

    logic [3:0]  last_resp [2];
    logic [3:0]  last_tag  [2];
    logic [31:0] last_data [2];
    logic        last_acc  [2];

    logic [31:0] pool [16];
    int tests;
    int fails;

    task automatic chk(input string n, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s got %h exp %h", n, obs, exp);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? L0 : L1;
    endfunction

    function automatic int max_of(input int i);
        return (i == 0) ? M0 : M1;
    endfunction

    // One cycle of the reference model for instance i: predict, compare, advance.
    task automatic model_cycle(input int i, input logic r);
        logic        comp;
        logic        acc;
        logic [3:0]  etag;
        logic [31:0] edata;
        logic [31:0] ld;
        int unsigned widx;
        bit          inr;
        pend_t       e;
        comp  = (pq[i].size() > 0) && (pq[i][0].done == cyc);
        etag  = comp ? pq[i][0].tag : 4'd0;
        edata = comp ? pq[i][0].data : 32'd0;
        acc   = r && (cmd[i] == 2'd1 || cmd[i] == 2'd2) && (outst[i] < max_of(i) || comp);
        chk($sformatf("u%0d_resp c%0d", i, cyc), 32'(resp[i]), acc ? 32'(ntag[i]) : 32'd0);
        chk($sformatf("u%0d_tag c%0d", i, cyc), 32'(otag[i]), 32'(etag));
        chk($sformatf("u%0d_data c%0d", i, cyc), odata[i], edata);
        last_resp[i] = resp[i];
        last_tag[i]  = otag[i];
        last_data[i] = odata[i];
        last_acc[i]  = acc;
        if (comp) begin
            void'(pq[i].pop_front());
            outst[i]--;
        end
        if (acc) begin
            widx = addr[i][31:2];
            inr  = (widx < DEPTH);
            ld   = 32'd0;
            if (cmd[i] == 2'd1 && inr) ld = mm[i][widx];
            if (cmd[i] == 2'd2 && inr) mm[i][widx] = wdata[i];
            e.tag  = ntag[i];
            e.data = ld;
            e.done = cyc + lat_of(i);
            pq[i].push_back(e);
            outst[i]++;
            ntag[i] = (ntag[i] == 4'd15) ? 4'd1 : ntag[i] + 4'd1;
        end
        if (!r) begin
            pq[i].delete();
            outst[i] = 0;
            ntag[i]  = 4'd1;
        end
    endtask

    task automatic step(input logic r,
                        input logic [1:0] c0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic [1:0] c1, input logic [31:0] a1, input logic [31:0] d1);
        rst = r;
        cmd[0] = c0; addr[0] = a0; wdata[0] = d0;
        cmd[1] = c1; addr[1] = a1; wdata[1] = d1;
        #4;
        model_cycle(0, r);
        model_cycle(1, r);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 2'd0, 32'd0, 32'd0, 2'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b0, 2'd1, 32'd0, 32'd0, 2'd1, 32'd0, 32'd0);
    endtask

    task automatic op0(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
        step(1'b1, c, a, d, 2'd0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned  p;
        logic [29:0]  w;
        p = $urandom_range(0, 19);
        if (p < 16)       w = 30'(p);
        else if (p == 16) w = 30'(DEPTH);
        else if (p == 17) w = 30'(DEPTH + 7);
        else              w = 30'h3FFF_FFFF;
        return {w, 2'($urandom_range(0, 3))};
    endfunction

    function automatic logic [1:0] rand_cmd();
        int unsigned p;
        p = $urandom_range(0, 9);
        if (p < 2) return 2'd0;
        if (p < 6) return 2'd1;
        if (p < 9) return 2'd2;
        return 2'd3;
    endfunction

    initial begin
        int w [2];
        int budget;
        logic [3:0] exp32_0 [7];
        logic [3:0] exp32_1 [7];
        tests = 0;
        fails = 0;
        cyc   = 0;
        for (int i = 0; i < 2; i++) begin
            outst[i] = 0;
            ntag[i]  = 4'd1;
            cmd[i]   = 2'd0;
            addr[i]  = 32'd0;
            wdata[i] = 32'd0;
        end
        for (int k = 0; k < 16; k++) pool[k] = $urandom;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with a LOAD held on the bus that must not be accepted
        do_reset();
        chk("rst_resp", 32'(last_resp[0]), 32'd0);
        chk("rst_tag", 32'(last_tag[0]), 32'd0);
        chk("rst_data", last_data[0], 32'd0);

        // Store then load at 0x10
        op0(2'd2, 32'h10, 32'hDEAD_BEEF);
        chk("seq_resp0", 32'(last_resp[0]), 32'd1);
        op0(2'd1, 32'h10, 32'd0);
        chk("seq_resp1", 32'(last_resp[0]), 32'd2);
        idle(3);
        chk("seq_tag_c4", 32'(last_tag[0]), 32'd1);
        chk("seq_data_c4", last_data[0], 32'd0);
        idle(1);
        chk("seq_tag_c5", 32'(last_tag[0]), 32'd2);
        chk("seq_data_c5", last_data[0], 32'hDEAD_BEEF);
        idle(6);

        // Fill words 0..15 of both instances, retrying on rejection
        w[0] = 0; w[1] = 0; budget = 0;
        while ((w[0] < 16 || w[1] < 16) && budget < 300) begin
            step(1'b1,
                 (w[0] < 16) ? 2'd2 : 2'd0, 32'(w[0] * 4), pool[w[0] & 15],
                 (w[1] < 16) ? 2'd2 : 2'd0, 32'(w[1] * 4), pool[w[1] & 15]);
            for (int i = 0; i < 2; i++) if (last_acc[i] && w[i] < 16) w[i]++;
            budget++;
        end
        if (w[0] < 16 || w[1] < 16) begin
            tests++; fails++;
            $display("FAIL fill_timeout got %0d/%0d words exp 16/16", w[0], w[1]);
        end
        idle(8);

        // Illegal command 3: no accept, no write
        op0(2'd3, 32'h0, 32'h1234_5678);
        chk("cmd3_resp", 32'(last_resp[0]), 32'd0);
        op0(2'd1, 32'h0, 32'd0);
        idle(4);
        chk("cmd3_word0", last_data[0], pool[0]);

        // Out-of-range store and load
        op0(2'd2, 32'(DEPTH * 4), 32'hCAFE_F00D);
        chk("oor_st_acc", 32'(last_resp[0] != 4'd0), 32'd1);
        op0(2'd1, 32'(DEPTH * 4), 32'd0);
        chk("oor_ld_acc", 32'(last_resp[0] != 4'd0), 32'd1);
        idle(4);
        chk("oor_ld_data", last_data[0], 32'd0);
        op0(2'd1, 32'h0, 32'd0);
        idle(4);
        chk("oor_word0", last_data[0], pool[0]);
        idle(4);

        // Reset while two loads are in flight
        do_reset();
        op0(2'd1, 32'h8, 32'd0);
        op0(2'd1, 32'hC, 32'd0);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            idle(1);
            chk($sformatf("flush_tag%0d", k), 32'(last_tag[0]), 32'd0);
        end
        op0(2'd1, 32'h8, 32'd0);
        chk("flush_resp", 32'(last_resp[0]), 32'd1);
        idle(4);
        chk("flush_data", last_data[0], pool[2]);
        idle(4);

        // Tag wrap over 16 back-to-back accepted requests
        do_reset();
        for (int k = 0; k < 16; k++) begin
            op0(2'd1, 32'(k * 4), 32'd0);
            chk($sformatf("wrap_resp%0d", k), 32'(last_resp[0]), 32'((k % 15) + 1));
        end
        idle(8);

        // Full queue: U0 keeps accepting thanks to same-cycle completion,
        // U1 (two slots, latency 6) has to refuse until its head retires.
        do_reset();
        exp32_0 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        exp32_1 = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3};
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 2'd1, 32'h4, 32'd0, 2'd1, 32'h4, 32'd0);
            chk($sformatf("full_u0_resp%0d", k), 32'(last_resp[0]), 32'(exp32_0[k]));
            chk($sformatf("full_u1_resp%0d", k), 32'(last_resp[1]), 32'(exp32_1[k]));
        end
        idle(8);

        // Random traffic on both instances with occasional reset
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 63) != 0),
                 rand_cmd(), rand_addr(), $urandom,
                 rand_cmd(), rand_addr(), $urandom);
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
